tm_frame_serializer: RTL
========================

# tm_frame_serializer

- Converts a byte stream of telemetry payload into a contiguous serial transfer-frame bitstream.
- Each frame is the 32-bit attached sync marker, then PAYLOAD_BYTES payload bytes, then an optional CRC-16, sent MSB first at one bit per clock.
- Sits directly upstream of the serial frame capture/recording stage.
- Drives that stage's data input with bit_out and its enable with bit_en.
- bit_en is high for exactly one uninterrupted frame; its falling edge marks the frame boundary.

## Interface
- PAYLOAD_BYTES, 1030, payload bytes per frame; legal range 1..4095.
- ASM, 32'h1ACFFC1D, sync marker sent before the payload.
- FILL_BYTE, 8'h55, byte inserted into a payload slot on underrun.
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low.
- start  in  1  request to begin a frame; sampled only in IDLE.
- byte_data  in  8  payload byte.
- byte_valid  in  1  byte_data is valid.
- byte_ready  out  1  block accepts byte_data this cycle.
- bit_out  out  1  serial frame bit.
- bit_en  out  1  bit_out is valid; high for exactly one frame length.
- busy  out  1  high from frame start until frame_done.
- frame_done  out  1  one-cycle pulse after the last frame bit.
- underrun  out  1  sticky; at least one fill byte was sent in this frame; cleared on accepted start.

## Operation
- States: IDLE, ASM, PAYLOAD, CRC (only with the macro), DONE.
- IDLE:
  - If start=1, latch ASM into the 32-bit shift register, clear underrun, load the slot counter with PAYLOAD_BYTES, go to ASM.
  - start is ignored in every other state.
- ASM:
  - Shift 32 bits out.
  - byte_ready may already be high so the first byte is prefetched.
  - After bit 31, go to PAYLOAD.
- Byte holding register:
  - One entry.
  - byte_ready = (state is ASM or PAYLOAD) && hold empty && unloaded slots > 0.
  - A transfer occurs when byte_valid && byte_ready.
- Byte boundary (last ASM bit or last bit of a payload byte), while slots remain:
  - The next byte loads into the shift register from one of three sources, in priority order:
    - the holding register;
    - a same-cycle transfer (bypass);
    - FILL_BYTE, which also sets underrun.
  - Every load consumes one slot, including a fill.
  - Frame length never changes.
  - Bytes beyond PAYLOAD_BYTES are never accepted.
- After the last payload bit: go to CRC if the macro is enabled, otherwise go to DONE.
- CRC: shift 16 CRC bits out, MSB first, then go to DONE.
- DONE:
  - bit_en=0, frame_done=1, busy=1 for one cycle.
  - Then go to IDLE.
- Reset, at any time including mid-frame:
  - State is IDLE; all counters, holding register and shift register are zero.
  - All outputs are 0.
- Widths:
  - Slot counter is 12 bits.
  - Bit counter is 5 bits, wrapping modulo 8 in PAYLOAD and modulo 32 in ASM.

## Timing
- Latency: start sampled in IDLE at edge N gives bit_en=1 and bit_out=ASM[31] from cycle N+1.
- bit_en stays high for 32+8·PAYLOAD_BYTES(+16) consecutive cycles.
  - Default frame with CRC: 8288 cycles.
  - Default frame without CRC: 8272 cycles.
- frame_done pulses in the first cycle after the last bit.
- Back-to-back frames with start held high leave a gap of exactly 2 cycles with bit_en=0.
- Upstream has 8 cycles per byte. A byte arriving on the boundary cycle itself is still used.

## Configuration
- FRAME_CRC_EN defined:
  - Appends CRC-16-CCITT: poly 0x1021, init 0xFFFF, no final XOR, no reflection.
  - The CRC covers the transmitted payload bits, fill bytes included; the ASM is excluded.
  - The CRC is updated bit-serially as payload bits leave.
- FRAME_CRC_EN undefined:
  - No CRC state and no CRC logic.
  - DONE follows PAYLOAD directly.

## Structure
- Shared package tm_pkg holds:
  - the state enum;
  - the default ASM constant;
  - CRC_POLY and CRC_INIT;
  - the slot-counter width.
- One sub-module, crc16_ccitt_serial:
  - Inputs: clk, rst, clear, bit_valid, bit_in.
  - Output: a 16-bit crc.
  - Instantiated only under FRAME_CRC_EN.

## Test plan
- Default params, FRAME_CRC_EN on, bytes always valid, start pulse -> first 32 bits are 0x1ACFFC1D, bit_en high for exactly 8288 cycles, frame_done pulses once, underrun=0.
- Payload byte i = i mod 256 with no stalls -> bits 32..8271 reproduce 0x00,0x01,… MSB first.
- PAYLOAD_BYTES=9, payload "123456789" (0x31..0x39) -> last 16 bits are 0x29B1, frame length 120 bits.
- byte_valid withheld through the whole slot-5 window -> slot 5 sent as 0x55, underrun=1, frame length unchanged, byte_ready low after the final slot.
- start pulsed while busy -> ignored.
- Reset asserted at frame bit 100 -> bit_en, bit_out, busy and byte_ready all 0 immediately; the next start produces a clean full frame.
- start held high across two frames -> exactly 2 bit_en-low cycles between frames, and underrun cleared at the second start.

Source files
------------

// File: rtl/tm_pkg.sv
// Shared types and constants for the telemetry frame serializer.
// The ST_CRC state exists only when FRAME_CRC_EN is defined.
package tm_pkg;

    localparam logic [31:0] ASM_DEFAULT = 32'h1ACFFC1D;
    localparam logic [15:0] CRC_POLY    = 16'h1021;
    localparam logic [15:0] CRC_INIT    = 16'hFFFF;
    localparam int unsigned SLOT_W      = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ASM,
        ST_PAYLOAD,
`ifdef FRAME_CRC_EN
        ST_CRC,
`endif
        ST_DONE
    } tm_state_e;

endpackage

// File: rtl/crc16_ccitt_serial.sv
// Bit-serial CRC-16-CCITT (poly 0x1021, init 0xFFFF, unreflected, no final XOR).
module crc16_ccitt_serial
    import tm_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        bit_valid,
    input  logic        bit_in,
    output logic [15:0] crc
);

    logic [15:0] crc_q, crc_d;
    logic        fb;

    always_comb begin
        fb    = crc_q[15] ^ bit_in;
        crc_d = crc_q;
        if (clear) begin
            crc_d = CRC_INIT;
        end else if (bit_valid) begin
            crc_d = {crc_q[14:0], 1'b0} ^ (fb ? CRC_POLY : '0);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/tm_frame_serializer.sv
// Serialises ASM + PAYLOAD_BYTES payload bytes (+ CRC-16 when FRAME_CRC_EN is
// defined) into one contiguous MSB-first bitstream, filling underrun slots.
module tm_frame_serializer
    import tm_pkg::*;
#(
    parameter int unsigned PAYLOAD_BYTES = 1030,
    parameter logic [31:0] ASM           = ASM_DEFAULT,
    parameter logic [7:0]  FILL_BYTE     = 8'h55
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] byte_data,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic       bit_out,
    output logic       bit_en,
    output logic       busy,
    output logic       frame_done,
    output logic       underrun
);

    tm_state_e         state_q, state_d;
    logic [31:0]       shift_q, shift_d;
    logic [4:0]        bit_cnt_q, bit_cnt_d;
    logic [SLOT_W-1:0] slots_q, slots_d;
    logic [7:0]        hold_q, hold_d;
    logic              hold_vld_q, hold_vld_d;
    logic              underrun_q, underrun_d;
    logic              xfer, boundary, frame_start, serial_bit;
    logic [7:0]        next_byte;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (start) state_d = ST_ASM;
            ST_ASM:     if (bit_cnt_q == 5'd31) state_d = ST_PAYLOAD;
            ST_PAYLOAD: if (bit_cnt_q == 5'd7 && slots_q == '0) begin
`ifdef FRAME_CRC_EN
                state_d = ST_CRC;
`else
                state_d = ST_DONE;
`endif
            end
`ifdef FRAME_CRC_EN
            ST_CRC:     if (bit_cnt_q == 5'd15) state_d = ST_DONE;
`endif
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
`ifdef FRAME_CRC_EN
        bit_en = (state_q == ST_ASM) || (state_q == ST_PAYLOAD) || (state_q == ST_CRC);
`else
        bit_en = (state_q == ST_ASM) || (state_q == ST_PAYLOAD);
`endif
        busy       = (state_q != ST_IDLE);
        frame_done = (state_q == ST_DONE);
        byte_ready = ((state_q == ST_ASM) || (state_q == ST_PAYLOAD))
                     && !hold_vld_q && (slots_q != '0);
        bit_out    = bit_en && serial_bit;
        underrun   = underrun_q;
    end

    // Byte-boundary source priority: holding register, same-cycle bypass, fill.
    always_comb begin
        xfer        = byte_valid && byte_ready;
        frame_start = (state_q == ST_IDLE) && start;
        boundary    = ((state_q == ST_ASM) && (bit_cnt_q == 5'd31))
                      || ((state_q == ST_PAYLOAD) && (bit_cnt_q == 5'd7));
        next_byte   = FILL_BYTE;
        if (hold_vld_q) begin
            next_byte = hold_q;
        end else if (xfer) begin
            next_byte = byte_data;
        end

        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        slots_d    = slots_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        underrun_d = underrun_q;

        if (frame_start) begin
            shift_d    = ASM;
            bit_cnt_d  = '0;
            slots_d    = SLOT_W'(PAYLOAD_BYTES);
            underrun_d = 1'b0;
        end else if (bit_en) begin
            shift_d   = {shift_q[30:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (xfer) begin
                hold_d     = byte_data;
                hold_vld_d = 1'b1;
            end
            if (boundary && slots_q != '0) begin
                shift_d    = {next_byte, 24'h000000};
                slots_d    = slots_q - SLOT_W'(1);
                hold_vld_d = 1'b0;
                if (!hold_vld_q && !xfer) begin
                    underrun_d = 1'b1;
                end
            end
            if (boundary || state_d != state_q) begin
                bit_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            slots_q    <= '0;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            slots_q    <= slots_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            underrun_q <= underrun_d;
        end
    end

`ifdef FRAME_CRC_EN
    logic [15:0] crc;

    // CRC register is frozen during ST_CRC, so it is read out by bit index.
    crc16_ccitt_serial u_crc (
        .clk       (clk),
        .rst       (rst),
        .clear     (frame_start),
        .bit_valid (state_q == ST_PAYLOAD),
        .bit_in    (shift_q[31]),
        .crc       (crc)
    );

    assign serial_bit = (state_q == ST_CRC) ? crc[4'd15 - bit_cnt_q[3:0]] : shift_q[31];
`else
    assign serial_bit = shift_q[31];
`endif

endmodule
